video_timing_gen: RTL and testbench

Raster timing and test-pattern source feeding the three per-channel TMDS encoders. Generates horizontal/vertical counters, `data_enable`, the DVI control pairs (hsync/vsync on blue, zeros on red/green) and 8-bit RGB pixels from a selectable built-in pattern. All outputs are registered and mutually aligned, so they connect directly to the encoder inputs.

---
 rtl/video_timing_pkg.sv | 37 +++
 rtl/video_timing_if.sv | 34 +++
 rtl/video_timing_gen_pattern_gen.sv | 42 ++++
 rtl/video_timing_gen.sv | 145 ++++++++++++++
 tb/tb_video_timing_gen.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator.
// Default 640x480@60 timing, pattern codes, colour-bar table.
package video_timing_pkg;

  localparam int VT_CW = 12;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_HS_POL   = 1'b0;
  localparam bit DEF_VS_POL   = 1'b0;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_GREY  = 2'd3
  } pattern_e;

  // Index 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000,
    24'h0000FF,
    24'hFF0000,
    24'hFF00FF,
    24'h00FF00,
    24'h00FFFF,
    24'hFFFF00,
    24'hFFFFFF
  };

endpackage

// File: rtl/video_timing_if.sv
// Raster output bundle towards the TMDS encoders.
// master: generator side; slave: encoder/controller side.
interface video_timing_if;
  import video_timing_pkg::*;

  logic             enable;
  logic [1:0]       pattern_sel;
  logic             data_enable;
  logic [7:0]       r_out;
  logic [7:0]       g_out;
  logic [7:0]       b_out;
  logic [1:0]       control_r;
  logic [1:0]       control_g;
  logic [1:0]       control_b;
  logic [VT_CW-1:0] x;
  logic [VT_CW-1:0] y;
  logic             frame_start;
  logic             line_start;

  modport master (
    input  enable, pattern_sel,
    output data_enable, r_out, g_out, b_out,
    output control_r, control_g, control_b,
    output x, y, frame_start, line_start
  );

  modport slave (
    output enable, pattern_sel,
    input  data_enable, r_out, g_out, b_out,
    input  control_r, control_g, control_b,
    input  x, y, frame_start, line_start
  );

endinterface

// File: rtl/video_timing_gen_pattern_gen.sv
// Combinational test-pattern source.
// pattern_i, x_i, y_i in; 24-bit rgb_o out.
module pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  pattern_e         pattern_i,
  input  logic [VT_CW-1:0] x_i,
  input  logic [VT_CW-1:0] y_i,
  output logic [23:0]      rgb_o
);

  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BAR_DIV = (BAR_W > 0) ? BAR_W : 1;
  localparam int BAR_END = 8 * BAR_W;

  logic [VT_CW-1:0] bar_idx;
  logic             unused_bits;

  assign unused_bits = ^{y_i[VT_CW-1:6], y_i[4:0],
                         bar_idx[VT_CW-1:3]};

  always_comb begin
    bar_idx = x_i / VT_CW'(BAR_DIV);
    rgb_o   = '0;
    unique case (pattern_i)
      PAT_BARS: begin
        if (int'(x_i) < BAR_END)
          rgb_o = BAR_RGB[bar_idx[2:0]];
      end
      PAT_CHECK: begin
        rgb_o = (x_i[5] ^ y_i[5]) ? 24'h000000
                                  : 24'hFFFFFF;
      end
      PAT_RAMP: rgb_o = {3{x_i[7:0]}};
      PAT_GREY: rgb_o = {3{8'h80}};
      default:  rgb_o = '0;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster counters, sync/DE decode and aligned output registers.
// clk, rst_n plain; all video I/O through video_timing_if.master.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = DEF_HS_POL,
  parameter bit VS_POL   = DEF_VS_POL
) (
  input logic            clk,
  input logic            rst_n,
  video_timing_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  localparam logic [VT_CW-1:0] H_LAST = VT_CW'(H_TOTAL - 1);
  localparam logic [VT_CW-1:0] V_LAST = VT_CW'(V_TOTAL - 1);
  localparam logic [1:0] CB_IDLE = {~VS_POL, ~HS_POL};

  if (H_TOTAL > (1 << VT_CW) || V_TOTAL > (1 << VT_CW))
  begin : g_size_chk
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 4096");
  end

  logic [VT_CW-1:0] hc_q, hc_d;
  logic [VT_CW-1:0] vc_q, vc_d;
  pattern_e         pat_q, pat_d, pat_cur;

  logic             de_q, de_d;
  logic [23:0]      rgb_q, rgb_d;
  logic [1:0]       cb_q, cb_d;
  logic [VT_CW-1:0] x_q, x_d;
  logic [VT_CW-1:0] y_q, y_d;
  logic             fs_q, fs_d;
  logic             ls_q, ls_d;

  logic        at_org;
  logic        de_now;
  logic        hs_on;
  logic        vs_on;
  logic [23:0] pat_rgb;

  // The pixel at (0,0) already uses the newly requested
  // pattern so a frame is never split between two patterns.
  always_comb begin
    at_org  = (hc_q == '0) && (vc_q == '0);
    pat_cur = at_org ? pattern_e'(vif.pattern_sel) : pat_q;
    de_now  = (int'(hc_q) < H_ACTIVE) &&
              (int'(vc_q) < V_ACTIVE);
    hs_on   = (int'(hc_q) >= HS_BEG) &&
              (int'(hc_q) < HS_END);
    vs_on   = (int'(vc_q) >= VS_BEG) &&
              (int'(vc_q) < VS_END);
  end

  pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pat (
    .pattern_i (pat_cur),
    .x_i       (hc_q),
    .y_i       (vc_q),
    .rgb_o     (pat_rgb)
  );

  always_comb begin
    hc_d  = '0;
    vc_d  = '0;
    pat_d = pat_q;
    de_d  = 1'b0;
    rgb_d = '0;
    cb_d  = CB_IDLE;
    x_d   = '0;
    y_d   = '0;
    fs_d  = 1'b0;
    ls_d  = 1'b0;
    if (vif.enable) begin
      hc_d = (hc_q == H_LAST) ? '0 : hc_q + VT_CW'(1);
      vc_d = vc_q;
      if (hc_q == H_LAST)
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + VT_CW'(1);
      if (at_org)
        pat_d = pat_cur;
      de_d  = de_now;
      rgb_d = de_now ? pat_rgb : '0;
      cb_d  = {vs_on ? VS_POL : ~VS_POL,
               hs_on ? HS_POL : ~HS_POL};
      x_d   = hc_q;
      y_d   = vc_q;
      fs_d  = at_org;
      ls_d  = (hc_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q  <= '0;
      vc_q  <= '0;
      pat_q <= PAT_BARS;
      de_q  <= 1'b0;
      rgb_q <= '0;
      cb_q  <= CB_IDLE;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
    end else begin
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      pat_q <= pat_d;
      de_q  <= de_d;
      rgb_q <= rgb_d;
      cb_q  <= cb_d;
      x_q   <= x_d;
      y_q   <= y_d;
      fs_q  <= fs_d;
      ls_q  <= ls_d;
    end
  end

  assign vif.data_enable = de_q;
  assign vif.r_out       = rgb_q[23:16];
  assign vif.g_out       = rgb_q[15:8];
  assign vif.b_out       = rgb_q[7:0];
  assign vif.control_r   = 2'b00;
  assign vif.control_g   = 2'b00;
  assign vif.control_b   = cb_q;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.frame_start = fs_q;
  assign vif.line_start  = ls_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen.
// Three instances: default timing, tiny raster, mid-size raster.
module tb_video_timing_gen;

  typedef struct packed {
    logic        de;
    logic [23:0] rgb;
    logic [1:0]  cr;
    logic [1:0]  cg;
    logic [1:0]  cb;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
    logic        ls;
  } obs_t;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    bit hp, vp;
  } tp_t;

  typedef struct {
    logic        en;
    logic [1:0]  sel;
    logic [11:0] x, y;
    logic        de;
    logic [23:0] rgb;
    logic [1:0]  cb;
    logic        fs, ls;
  } vec_t;

  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] sel;

  int   nchk;
  int   nerr;
  int   t;
  int   mpat;
  int   dut_sel;
  tp_t  P;
  vec_t tbl [13];

  video_timing_if ifa ();
  video_timing_if ifb ();
  video_timing_if ifc ();

  assign ifa.enable      = en;
  assign ifa.pattern_sel = sel;
  assign ifb.enable      = en;
  assign ifb.pattern_sel = sel;
  assign ifc.enable      = en;
  assign ifc.pattern_sel = sel;

  video_timing_gen u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (ifa)
  );

  video_timing_gen #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b1), .VS_POL (1'b1)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (ifb)
  );

  video_timing_gen #(
    .H_ACTIVE (320), .H_FP (8), .H_SYNC (32), .H_BP (40),
    .V_ACTIVE (24), .V_FP (2), .V_SYNC (2), .V_BP (4),
    .HS_POL (1'b0), .VS_POL (1'b0)
  ) u_c (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic string fmt(obs_t o);
    return $sformatf(
      "de=%0d rgb=%06h cr=%b cg=%b cb=%b x=%0d y=%0d fs=%0d ls=%0d",
      o.de, o.rgb, o.cr, o.cg, o.cb, o.x, o.y, o.fs, o.ls);
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 25)
        $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_obs(string nm, obs_t a, obs_t e);
    nchk++;
    if (a !== e) begin
      nerr++;
      if (nerr <= 25)
        $display("FAIL %s got {%s} want {%s}",
                 nm, fmt(a), fmt(e));
    end
  endtask

  function automatic obs_t grab();
    obs_t o;
    case (dut_sel)
      0: o = {ifa.data_enable, ifa.r_out, ifa.g_out, ifa.b_out,
              ifa.control_r, ifa.control_g, ifa.control_b,
              ifa.x, ifa.y, ifa.frame_start, ifa.line_start};
      1: o = {ifb.data_enable, ifb.r_out, ifb.g_out, ifb.b_out,
              ifb.control_r, ifb.control_g, ifb.control_b,
              ifb.x, ifb.y, ifb.frame_start, ifb.line_start};
      default:
         o = {ifc.data_enable, ifc.r_out, ifc.g_out, ifc.b_out,
              ifc.control_r, ifc.control_g, ifc.control_b,
              ifc.x, ifc.y, ifc.frame_start, ifc.line_start};
    endcase
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o    = '0;
    o.cb = {~P.vp, ~P.hp};
    return o;
  endfunction

  // Reference pixel from the raster rules at position (h,v).
  function automatic obs_t ref_pix(int h, int v, int pat);
    obs_t o;
    bit   hs, vs;
    int   bw;
    o    = '0;
    o.x  = 12'(h);
    o.y  = 12'(v);
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    hs   = (h >= P.ha + P.hf) && (h < P.ha + P.hf + P.hs);
    vs   = (v >= P.va + P.vf) && (v < P.va + P.vf + P.vs);
    o.cb = {vs ? P.vp : ~P.vp, hs ? P.hp : ~P.hp};
    o.de = (h < P.ha) && (v < P.va);
    if (o.de) begin
      case (pat)
        0: begin
          bw = P.ha / 8;
          for (int b = 0; b < 8; b++)
            if (h >= b * bw && h < (b + 1) * bw)
              o.rgb = BARS[b];
        end
        1: o.rgb = (((h / 32) % 2) != ((v / 32) % 2))
                   ? 24'h000000 : 24'hFFFFFF;
        2: o.rgb = {3{8'(h % 256)}};
        default: o.rgb = 24'h808080;
      endcase
    end
    return o;
  endfunction

  // One clock: predict, clock, sample, compare.
  task automatic step(output obs_t a);
    obs_t e;
    int   ht, ft;
    ht = P.ha + P.hf + P.hs + P.hb;
    ft = ht * (P.va + P.vf + P.vs + P.vb);
    if (en) begin
      if (t == 0) mpat = int'(sel);
      e = ref_pix(t % ht, t / ht, mpat);
      t = (t + 1) % ft;
    end else begin
      e = idle_obs();
      t = 0;
    end
    @(posedge clk);
    #1;
    a = grab();
    chk_obs("raster", a, e);
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    sel   = 2'd0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    t     = 0;
    mpat  = 0;
  endtask

  task automatic fill_table();
    tbl[0]  = '{1, 0, 0, 0, 1, 24'hFFFFFF, 2'b00, 1, 1};
    tbl[1]  = '{1, 0, 1, 0, 1, 24'hFFFF00, 2'b00, 0, 0};
    tbl[2]  = '{1, 0, 2, 0, 1, 24'h00FFFF, 2'b00, 0, 0};
    tbl[3]  = '{1, 0, 3, 0, 1, 24'h00FF00, 2'b00, 0, 0};
    tbl[4]  = '{1, 0, 4, 0, 1, 24'hFF00FF, 2'b00, 0, 0};
    tbl[5]  = '{1, 0, 5, 0, 1, 24'hFF0000, 2'b00, 0, 0};
    tbl[6]  = '{1, 0, 6, 0, 1, 24'h0000FF, 2'b00, 0, 0};
    tbl[7]  = '{1, 0, 7, 0, 1, 24'h000000, 2'b00, 0, 0};
    tbl[8]  = '{1, 0, 8, 0, 0, 24'h000000, 2'b00, 0, 0};
    tbl[9]  = '{1, 0, 9, 0, 0, 24'h000000, 2'b01, 0, 0};
    tbl[10] = '{1, 0, 10, 0, 0, 24'h000000, 2'b01, 0, 0};
    tbl[11] = '{1, 0, 11, 0, 0, 24'h000000, 2'b00, 0, 0};
    tbl[12] = '{1, 0, 0, 1, 1, 24'hFFFFFF, 2'b00, 0, 1};
  endtask

  initial begin
    obs_t a, e;
    int   last_ls, hs_fall, de_cnt;
    bit   prev_hs, found;

    nchk  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 2'd0;
    t     = 0;
    mpat  = 0;
    fill_table();

    // Default timing: reset values, line/hsync/DE structure.
    P       = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    dut_sel = 0;
    hold_reset();
    a = grab();
    chk("rst_de", a.de, 0);
    chk("rst_rgb", a.rgb, 0);
    chk("rst_cb", a.cb, 2'b11);
    chk("rst_crcg", {a.cr, a.cg}, 4'b0000);
    chk("rst_xy", {a.x, a.y}, 0);
    chk("rst_pulses", {a.fs, a.ls}, 0);
    release_reset();
    last_ls = -1;
    hs_fall = -1;
    de_cnt  = 0;
    prev_hs = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      step(a);
      if (i == 0) chk("first_fs", a.fs, 1);
      if (a.ls) begin
        if (last_ls >= 0) begin
          chk("line_period", 64'(i - last_ls), 800);
          chk("de_per_line", 64'(de_cnt), 640);
        end
        last_ls = i;
        de_cnt  = 0;
      end
      if (a.de) de_cnt++;
      if (!a.cb[0] && prev_hs) begin
        chk("hs_start_x", a.x, 656);
        hs_fall = i;
      end
      if (a.cb[0] && !prev_hs && hs_fall >= 0)
        chk("hs_width", 64'(i - hs_fall), 96);
      prev_hs = a.cb[0];
    end

    // Asynchronous reset between edges, mid-line.
    #3;
    rst_n = 1'b0;
    #1;
    a = grab();
    chk_obs("async_rst", a, idle_obs());
    repeat (2) @(posedge clk);
    #2;
    release_reset();
    step(a);
    chk("post_rst_fs", {a.fs, a.x, a.y}, {1'b1, 24'h0});

    // Tiny raster, active-high syncs: table vectors.
    P       = '{8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1};
    dut_sel = 1;
    hold_reset();
    a = grab();
    chk("b_rst_cb", a.cb, 2'b00);
    release_reset();
    for (int i = 0; i < 13; i++) begin
      en  = tbl[i].en;
      sel = tbl[i].sel;
      @(posedge clk);
      #1;
      a    = grab();
      e    = '0;
      e.de = tbl[i].de;
      e.rgb = tbl[i].rgb;
      e.cb = tbl[i].cb;
      e.x  = tbl[i].x;
      e.y  = tbl[i].y;
      e.fs = tbl[i].fs;
      e.ls = tbl[i].ls;
      chk_obs($sformatf("vec%0d", i), a, e);
    end
    t    = 13;
    mpat = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 59) != 0);
      step(a);
    end

    // Mid-size raster: pattern switch mid-frame.
    P       = '{320, 8, 32, 40, 24, 2, 2, 4, 1'b0, 1'b0};
    dut_sel = 2;
    hold_reset();
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      step(a);
      if (a.x == 100 && a.y == 10) found = 1'b1;
    end
    chk("reach_100_10", found, 1);
    sel   = 2'd2;
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      step(a);
      if (a.x == 200 && a.y == 11)
        chk("bars_hold", a.rgb, 24'hFF0000);
      if (a.x == 300 && a.y == 0) begin
        chk("ramp_x300", a.rgb, 24'h2C2C2C);
        found = 1'b1;
      end
    end
    chk("reach_next_frame", found, 1);

    // Enable dropped for 5 cycles at (320,20).
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      step(a);
      if (a.x == 320 && a.y == 20) found = 1'b1;
    end
    chk("reach_320_20", found, 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(a);
      chk("dis_idle", {a.de, a.cb, a.fs, a.ls}, 5'b0_11_00);
    end
    en = 1'b1;
    step(a);
    chk("reen_origin", {a.de, a.fs, a.x, a.y},
        {2'b11, 24'h0});

    // Randomised run against the model.
    for (int i = 0; i < 13000; i++) begin
      if ($urandom_range(0, 299) == 0) sel = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 1999) != 0);
      step(a);
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
